agc_stream: RTL and testbench

Automatic gain control stage for the receiver's complex input stream, placed directly upstream of the `modulus` stage and occupying the AGC slave slot (address field 0x1) of the DSP subsystem AHB decoder. It scales each 32-bit I/Q sample by a Q8.8 gain and saturates the result. In automatic mode it tracks the per-window peak magnitude and steps the gain toward a programmable target with hysteresis. Configuration and status are exposed through a zero-wait-state AHB slave.

---
 rtl/agc_stream.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_agc_stream.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_stream.sv
// agc_stream: automatic gain control for the complex I/Q receive stream.
// Q8.8 gain, saturating scaler, windowed peak tracker, AHB config slave.
module agc_stream #(
  parameter int          WIN_LOG2 = 10,
  parameter logic [15:0] GAIN_MIN = 16'h0010,
  parameter logic [15:0] GAIN_MAX = 16'h4000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [31:0] tdata_s,
  input  logic        tvalid_s,
  output logic        tready_s,
  output logic [31:0] tdata_m,
  output logic        tvalid_m,
  input  logic        tready_m,
  input  logic [31:0] haddr_s,
  input  logic [2:0]  hburst_s,
  input  logic [2:0]  hsize_s,
  input  logic [1:0]  htrans_s,
  input  logic [31:0] hwdata_s,
  input  logic        hwrite_s,
  input  logic        hsel_s,
  output logic [31:0] hrdata_s,
  output logic        hreadyout_s,
  output logic        hresp_s,
  output logic        irq
);

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_TGT  = 3'd1;
  localparam logic [2:0] A_HYST = 3'd2;
  localparam logic [2:0] A_STEP = 3'd3;
  localparam logic [2:0] A_MAN  = 3'd4;
  localparam logic [2:0] A_CUR  = 3'd5;
  localparam logic [2:0] A_PEAK = 3'd6;
  localparam logic [2:0] A_SAT  = 3'd7;

  // AHB pipeline state
  logic [2:0]  r_addr;
  logic        r_wr;
  logic        r_rd;

  // configuration
  logic [1:0]  r_ctrl;
  logic [15:0] r_target;
  logic [15:0] r_hyst;
  logic [15:0] r_step;
  logic [15:0] r_man;

  // status / tracking
  logic [15:0] r_gain;
  logic [15:0] r_last_peak;
  logic [15:0] r_peak;
  logic [31:0] r_sat;
  logic [WIN_LOG2-1:0] r_cnt;
  logic        r_win_end;
  logic        r_irq;

  // output stage
  logic        r_tvalid;
  logic [31:0] r_tdata;

  logic        w_xfer;
  logic        w_wr_ctrl;
  logic        w_wr_tgt;
  logic        w_wr_hyst;
  logic        w_wr_step;
  logic        w_wr_man;
  logic        w_wr_sat;
  logic [15:0] w_man_next;
  logic        w_acc;
  logic        w_wrap;

  logic signed [32:0] w_xi;
  logic signed [32:0] w_xq;
  logic signed [32:0] w_g;
  logic signed [32:0] w_pi;
  logic signed [32:0] w_pq;
  logic        w_si;
  logic        w_sq;
  logic [15:0] w_oi;
  logic [15:0] w_oq;

  logic [15:0] w_ai;
  logic [15:0] w_aq;
  logic [15:0] w_mag;
  logic [15:0] w_pk;

  logic [16:0] w_thr_hi;
  logic [16:0] w_lp_lo;
  logic        w_dn;
  logic        w_up;
  logic [16:0] w_sub;
  logic [16:0] w_add;
  logic [15:0] w_gdn;
  logic [15:0] w_gup;
  logic        w_upd;
  logic        w_clamp;

  logic [31:0] w_rd;
  logic        w_unused;

  assign w_unused = ^{hburst_s, hsize_s, haddr_s[31:5],
                      haddr_s[1:0], htrans_s[0],
                      hwdata_s[31:16]};

  assign hreadyout_s = 1'b1;
  assign hresp_s     = 1'b0;
  assign tready_s    = !r_tvalid | tready_m;
  assign tvalid_m    = r_tvalid;
  assign tdata_m     = r_tdata;
  assign irq         = r_irq;

  assign w_xfer    = hsel_s & htrans_s[1];
  assign w_wr_ctrl = r_wr & (r_addr == A_CTRL);
  assign w_wr_tgt  = r_wr & (r_addr == A_TGT);
  assign w_wr_hyst = r_wr & (r_addr == A_HYST);
  assign w_wr_step = r_wr & (r_addr == A_STEP);
  assign w_wr_man  = r_wr & (r_addr == A_MAN);
  assign w_wr_sat  = r_wr & (r_addr == A_SAT);

  assign w_man_next = w_wr_man ? hwdata_s[15:0] : r_man;

  assign w_acc  = ce & tvalid_s & tready_s;
  assign w_wrap = w_acc & (&r_cnt);

  // scaler: signed sample times unsigned Q8.8 gain
  assign w_xi = {{17{tdata_s[15]}}, tdata_s[15:0]};
  assign w_xq = {{17{tdata_s[31]}}, tdata_s[31:16]};
  assign w_g  = {17'd0, r_gain};
  assign w_pi = w_xi * w_g;
  assign w_pq = w_xq * w_g;

  // result fits in 16 bits only if bits 32..23 agree
  assign w_si = !((&w_pi[32:23]) | (~|w_pi[32:23]));
  assign w_sq = !((&w_pq[32:23]) | (~|w_pq[32:23]));

  assign w_oi = w_si ? {w_pi[32], {15{~w_pi[32]}}}
                     : w_pi[23:8];
  assign w_oq = w_sq ? {w_pq[32], {15{~w_pq[32]}}}
                     : w_pq[23:8];

  // pre-gain magnitude; -32768 maps to 0x8000
  assign w_ai  = tdata_s[15] ? (16'd0 - tdata_s[15:0])
                             : tdata_s[15:0];
  assign w_aq  = tdata_s[31] ? (16'd0 - tdata_s[31:16])
                             : tdata_s[31:16];
  assign w_mag = (w_ai > w_aq) ? w_ai : w_aq;
  assign w_pk  = (w_mag > r_peak) ? w_mag : r_peak;

  // gain step decision with hysteresis band
  assign w_thr_hi = {1'b0, r_target} + {1'b0, r_hyst};
  assign w_lp_lo  = {1'b0, r_last_peak} + {1'b0, r_hyst};
  assign w_dn     = {1'b0, r_last_peak} > w_thr_hi;
  assign w_up     = !w_dn & (w_lp_lo < {1'b0, r_target});

  assign w_sub = {1'b0, r_gain} - {1'b0, r_step};
  assign w_add = {1'b0, r_gain} + {1'b0, r_step};
  assign w_gdn = (w_sub[16] || (w_sub[15:0] < GAIN_MIN))
               ? GAIN_MIN : w_sub[15:0];
  assign w_gup = (w_add > {1'b0, GAIN_MAX})
               ? GAIN_MAX : w_add[15:0];

  assign w_upd   = ce & r_win_end & r_ctrl[0] & !r_ctrl[1];
  assign w_clamp = (w_dn & (w_gdn == GAIN_MIN))
                 | (w_up & (w_gup == GAIN_MAX));

  // AHB address phase capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr <= 3'd0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
    end else begin
      r_addr <= haddr_s[4:2];
      r_wr   <= w_xfer & hwrite_s;
      r_rd   <= w_xfer & !hwrite_s;
    end
  end

  // configuration registers, written in the data phase
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ctrl   <= 2'd0;
      r_target <= 16'h4000;
      r_hyst   <= 16'h0800;
      r_step   <= 16'h0010;
      r_man    <= 16'h0100;
    end else begin
      if (w_wr_ctrl) r_ctrl   <= hwdata_s[1:0];
      if (w_wr_tgt)  r_target <= hwdata_s[15:0];
      if (w_wr_hyst) r_hyst   <= hwdata_s[15:0];
      if (w_wr_step) r_step   <= hwdata_s[15:0];
      r_man <= w_man_next;
    end
  end

  // window counter and running peak
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_peak      <= 16'd0;
      r_last_peak <= 16'd0;
    end else if (w_wr_ctrl) begin
      r_cnt  <= '0;
      r_peak <= 16'd0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + WIN_LOG2'(1);
      if (&r_cnt) begin
        r_peak      <= 16'd0;
        r_last_peak <= w_pk;
      end else begin
        r_peak <= w_pk;
      end
    end
  end

  // one-cycle marker that a window just closed
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_win_end <= 1'b0;
    end else if (ce) begin
      r_win_end <= w_wrap & !w_wr_ctrl;
    end
  end

  // saturation event counter, sticky at all-ones
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sat <= 32'd0;
    end else if (w_wr_sat) begin
      r_sat <= 32'd0;
    end else if (w_acc & (w_si | w_sq) & ~&r_sat) begin
      r_sat <= r_sat + 32'd1;
    end
  end

  // current gain: manual tracking or windowed auto steps
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_gain <= 16'h0100;
    end else if (ce) begin
      if (!r_ctrl[0]) begin
        r_gain <= w_man_next;
      end else if (w_upd & w_dn) begin
        r_gain <= w_gdn;
      end else if (w_upd & w_up) begin
        r_gain <= w_gup;
      end
    end
  end

  // clamp interrupt pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_upd & w_clamp;
    end
  end

  // output register with stall hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tvalid <= 1'b0;
      r_tdata  <= 32'd0;
    end else if (ce & tready_s) begin
      r_tvalid <= tvalid_s;
      if (w_acc) r_tdata <= {w_oq, w_oi};
    end
  end

  // read mux for the data phase
  always_comb begin
    w_rd = 32'd0;
    unique case (r_addr)
      A_CTRL: w_rd = {30'd0, r_ctrl};
      A_TGT:  w_rd = {16'd0, r_target};
      A_HYST: w_rd = {16'd0, r_hyst};
      A_STEP: w_rd = {16'd0, r_step};
      A_MAN:  w_rd = {16'd0, r_man};
      A_CUR:  w_rd = {16'd0, r_gain};
      A_PEAK: w_rd = {16'd0, r_last_peak};
      A_SAT:  w_rd = r_sat;
      default: w_rd = 32'd0;
    endcase
  end

  assign hrdata_s = r_rd ? w_rd : 32'd0;

endmodule

// File: tb/tb_agc_stream.sv
// tb_agc_stream: randomized stream + AHB directed steps for agc_stream,
// checked cycle by cycle against an arithmetic reference model.
module tb_agc_stream;

  localparam int WL   = 4;
  localparam int N    = 1 << WL;
  localparam int GMIN = 16'h0010;
  localparam int GMAX = 16'h4000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic [31:0] tdata_s;
  logic        tvalid_s;
  logic        tready_s;
  logic [31:0] tdata_m;
  logic        tvalid_m;
  logic        tready_m;
  logic [31:0] haddr_s;
  logic [2:0]  hburst_s;
  logic [2:0]  hsize_s;
  logic [1:0]  htrans_s;
  logic [31:0] hwdata_s;
  logic        hwrite_s;
  logic        hsel_s;
  logic [31:0] hrdata_s;
  logic        hreadyout_s;
  logic        hresp_s;
  logic        irq;

  agc_stream #(
    .WIN_LOG2(WL),
    .GAIN_MIN(16'h0010),
    .GAIN_MAX(16'h4000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .tdata_s(tdata_s), .tvalid_s(tvalid_s),
    .tready_s(tready_s),
    .tdata_m(tdata_m), .tvalid_m(tvalid_m),
    .tready_m(tready_m),
    .haddr_s(haddr_s), .hburst_s(hburst_s),
    .hsize_s(hsize_s), .htrans_s(htrans_s),
    .hwdata_s(hwdata_s), .hwrite_s(hwrite_s),
    .hsel_s(hsel_s), .hrdata_s(hrdata_s),
    .hreadyout_s(hreadyout_s), .hresp_s(hresp_s),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_irq  = 0;

  // reference model state
  bit          mv;
  logic [31:0] md;
  int          m_gain;
  logic [1:0]  m_ctrl;
  int          m_tgt, m_hyst, m_step, m_man;
  int          m_lp, m_peak, m_wcnt;
  logic [31:0] m_sat;
  bit          pend;
  bit          exp_irq;
  bit          w_pend;
  logic [2:0]  w_a;
  logic [31:0] w_d;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] scale(
      input logic [15:0] v, input int g, output bit s);
    longint x, p, y;
    x = longint'($signed(v));
    p = x * longint'(g);
    if (p >= 0) y = p / 256;
    else        y = -((-p + 255) / 256);
    s = 1'b1;
    if (y > 32767)       y = 32767;
    else if (y < -32768) y = -32768;
    else                 s = 1'b0;
    return y[15:0];
  endfunction

  function automatic int mag16(input logic [15:0] v);
    int x;
    x = int'($signed(v));
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    case (a)
      3'd0: return {30'd0, m_ctrl};
      3'd1: return 32'(m_tgt);
      3'd2: return 32'(m_hyst);
      3'd3: return 32'(m_step);
      3'd4: return 32'(m_man);
      3'd5: return 32'(m_gain);
      3'd6: return 32'(m_lp);
      default: return m_sat;
    endcase
  endfunction

  task automatic model_reset();
    mv = 0; md = 32'd0; m_gain = 16'h0100;
    m_ctrl = 2'd0; m_tgt = 16'h4000; m_hyst = 16'h0800;
    m_step = 16'h0010; m_man = 16'h0100;
    m_lp = 0; m_peak = 0; m_wcnt = 0; m_sat = 32'd0;
    pend = 0; exp_irq = 0; w_pend = 0;
  endtask

  task automatic auto_step();
    int ng;
    if (m_lp > m_tgt + m_hyst) begin
      ng = m_gain - m_step;
      if (ng < GMIN) ng = GMIN;
      exp_irq = (ng == GMIN);
      m_gain = ng;
    end else if (m_lp + m_hyst < m_tgt) begin
      ng = m_gain + m_step;
      if (ng > GMAX) ng = GMAX;
      exp_irq = (ng == GMAX);
      m_gain = ng;
    end
  endtask

  // one clock: inputs already driven by the caller
  task automatic tick();
    bit rdy, acc, si, sq, np;
    logic [15:0] oi, oq;
    int mg;
    #2;
    rdy = !mv || tready_m;
    if (reset_n) chk("tready_s", 32'(tready_s), 32'(rdy));
    acc = reset_n && ce && tvalid_s && rdy;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      model_reset();
      chk("rst_hrdata", hrdata_s, 32'd0);
    end else begin
      exp_irq = 0;
      np = 0;
      if (ce) begin
        if (acc) begin
          oi = scale(tdata_s[15:0], m_gain, si);
          oq = scale(tdata_s[31:16], m_gain, sq);
          md = {oq, oi};
          if ((si || sq) && m_sat != 32'hFFFF_FFFF)
            m_sat = m_sat + 32'd1;
          mg = mag16(tdata_s[15:0]);
          if (mag16(tdata_s[31:16]) > mg)
            mg = mag16(tdata_s[31:16]);
          if (mg > m_peak) m_peak = mg;
          m_wcnt++;
          if (m_wcnt == N) begin
            m_lp = m_peak; m_peak = 0; m_wcnt = 0; np = 1;
          end
        end
        if (rdy) mv = tvalid_s;
        if (!m_ctrl[0])
          m_gain = (w_pend && w_a == 3'd4)
                 ? int'(w_d[15:0]) : m_man;
        else if (pend && !m_ctrl[1])
          auto_step();
        pend = np;
      end
      if (w_pend) begin
        case (w_a)
          3'd0: begin
            m_ctrl = w_d[1:0]; m_peak = 0; m_wcnt = 0;
          end
          3'd1: m_tgt  = int'(w_d[15:0]);
          3'd2: m_hyst = int'(w_d[15:0]);
          3'd3: m_step = int'(w_d[15:0]);
          3'd4: m_man  = int'(w_d[15:0]);
          3'd7: m_sat  = 32'd0;
          default: ;
        endcase
        w_pend = 0;
      end
    end
    if (irq === 1'b1) n_irq++;
    chk("tvalid_m", 32'(tvalid_m), 32'(mv));
    chk("tdata_m", tdata_m, md);
    chk("irq", 32'(irq), 32'(exp_irq));
    chk("hready", {hresp_s, hreadyout_s}, 32'd1);
  endtask

  task automatic ahb_rd(input logic [31:0] a,
                        output logic [31:0] v);
    tvalid_s = 0;
    hsel_s = 1; htrans_s = 2'b10; hwrite_s = 0; haddr_s = a;
    tick();
    v = hrdata_s;
    chk("rd", v, model_reg(a[4:2]));
    hsel_s = 0; htrans_s = 2'b00;
  endtask

  // write, then read the same register in the very next cycle
  task automatic ahb_wr(input logic [31:0] a,
                        input logic [31:0] d);
    tvalid_s = 0;
    hsel_s = 1; htrans_s = 2'b10; hwrite_s = 1; haddr_s = a;
    tick();
    hwrite_s = 0; hwdata_s = d;
    w_pend = 1; w_a = a[4:2]; w_d = d;
    tick();
    chk("wr_readback", hrdata_s, model_reg(a[4:2]));
    hsel_s = 0; htrans_s = 2'b00;
  endtask

  task automatic stream(input int n, input logic [31:0] fx,
                        input bit rnd, input int vp, input int rp);
    for (int i = 0; i < n; i++) begin
      tvalid_s = ($urandom_range(0, 99) < vp);
      tdata_s  = rnd ? $urandom : fx;
      tready_m = ($urandom_range(0, 99) < rp);
      tick();
    end
    tvalid_s = 0;
    tready_m = 1;
  endtask

  logic [31:0] rv;
  int          irq_mark;

  initial begin
    reset_n = 0; ce = 1; tvalid_s = 0; tdata_s = 0;
    tready_m = 1; hsel_s = 0; htrans_s = 0; hwrite_s = 0;
    haddr_s = 0; hwdata_s = 0; hburst_s = 0; hsize_s = 3'd2;
    model_reset();
    tick();
    reset_n = 1;
    for (int a = 0; a < 8; a++) ahb_rd(32'(a * 4), rv);
    ahb_rd(32'h14, rv);
    chk("rst_cur_gain", rv, 32'h0100);

    stream(20, {-16'sd5678, 16'sd1234}, 0, 100, 100);
    tick();
    chk("unity_out", tdata_m, 32'hE9D2_04D2);

    for (int k = 0; k < 4; k++) begin
      ahb_wr(32'h10, 32'($urandom_range(0, 16'h0800)));
      stream(60, 32'd0, 1, 70, 60);
    end

    ahb_wr(32'h10, 32'h0400);
    ahb_wr(32'h1C, 32'd0);
    stream(1, {-16'sd8193, 16'sh2000}, 0, 100, 100);
    tick();
    chk("sat_out", tdata_m, 32'h8000_7FFF);
    ahb_rd(32'h1C, rv);
    chk("sat_cnt_one", rv, 32'd1);
    ahb_wr(32'h1C, 32'hDEAD_BEEF);
    ahb_rd(32'h1C, rv);
    chk("sat_cnt_clr", rv, 32'd0);

    ahb_wr(32'h0C, 32'h0100);
    ahb_wr(32'h10, 32'h0100);
    ahb_wr(32'h00, 32'h1);
    stream(6 * N, 32'h0000_1000, 0, 100, 100);
    ahb_rd(32'h14, rv);
    chk("conv_gain", rv, 32'h0700);
    ahb_rd(32'h18, rv);
    chk("conv_peak", rv, 32'h1000);

    ahb_wr(32'h04, 32'h1000);
    irq_mark = n_irq;
    stream(30 * N, 32'h0000_7FFF, 0, 80, 50);
    ahb_rd(32'h14, rv);
    chk("clamp_gain", rv, 32'h0010);
    chk("clamp_irq_seen", 32'(n_irq > irq_mark + 2), 32'd1);

    ahb_wr(32'h00, 32'h3);
    irq_mark = n_irq;
    stream(8 * N, 32'h0000_7FFF, 0, 90, 70);
    chk("freeze_irq", 32'(n_irq), 32'(irq_mark));
    ahb_rd(32'h14, rv);
    chk("freeze_gain", rv, 32'h0010);

    ahb_wr(32'h00, 32'h0);
    stream(40, 32'd0, 1, 70, 50);
    ce = 0;
    stream(6, 32'd0, 1, 100, 100);
    ce = 1;
    stream(20, 32'd0, 1, 80, 80);

    stream(10, 32'd0, 1, 100, 100);
    tvalid_s = 1; tdata_s = $urandom; reset_n = 0;
    tick();
    reset_n = 1; tvalid_s = 0;
    chk("rst_tvalid", 32'(tvalid_m), 32'd0);
    ahb_rd(32'h14, rv);
    chk("rst_mid_gain", rv, 32'h0100);
    ahb_rd(32'h00, rv);
    chk("rst_mid_ctrl", rv, 32'd0);
    ahb_rd(32'h04, rv);
    chk("rst_mid_tgt", rv, 32'h4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
